// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants and state encoding for the I2C transaction scheduler
package i2c_pkg;

    localparam logic [1:0] RW_IDLE    = 2'b00;
    localparam logic [1:0] RW_WR      = 2'b10;
    localparam logic [1:0] RW_RD      = 2'b01;
    localparam logic [7:0] I2C_RD_BIT = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLO,
        S_WHI,
        S_RIDLE,
        S_RARM,
        S_RLO,
        S_RHI,
        S_FIN
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first requester at or after ptr
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + k) % NREQ))) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_xact_sched.sv
// rtl/i2c_xact_sched.sv - round-robin scheduler of register transactions onto one I2C byte master
module i2c_xact_sched
    import i2c_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int MAXLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rd,
    input  logic [NREQ*8-1:0] req_dev,
    input  logic [NREQ*8-1:0] req_addr,
    input  logic [NREQ*7-1:0] req_len,
    input  logic [NREQ*8-1:0] cl_wdata,
    output logic [NREQ-1:0]   cl_wtake,
    output logic [7:0]        cl_rdata,
    output logic [NREQ-1:0]   cl_rvalid,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    input  logic              sclk,
    input  logic              sda,
    output logic [1:0]        rw,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    input  logic              rd_ready,
    input  logic [7:0]        rd_in
);

    localparam int         PW       = $clog2(NREQ);
    localparam logic [6:0] MAX_LEN7 = 7'(MAXLEN);

    sched_state_t    state;
    logic [PW-1:0]   ptr, sel, win_idx, ptr_next;
    logic [NREQ-1:0] arb_gnt;
    logic            lat_rd, rphase, bus_idle;
    logic [7:0]      lat_dev, lat_addr;
    logic [6:0]      lat_len, cnt, wr_total, win_len;
    logic [7:0]      dev_a   [NREQ];
    logic [7:0]      addr_a  [NREQ];
    logic [7:0]      wdata_a [NREQ];
    logic [6:0]      len_a   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign dev_a[i]   = req_dev[i*8 +: 8];
        assign addr_a[i]  = req_addr[i*8 +: 8];
        assign wdata_a[i] = cl_wdata[i*8 +: 8];
        assign len_a[i]   = req_len[i*7 +: 7];
    end

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (arb_gnt[j]) win_idx = PW'(j);
        end
    end

    assign bus_idle = sclk && sda;
    assign win_len  = (len_a[win_idx] > MAX_LEN7) ? MAX_LEN7 : len_a[win_idx];
    assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    // A read only writes dev+addr before the repeated start; a write appends the payload.
    assign wr_total = lat_rd ? 7'd2 : lat_len + 7'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            sel       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= '0;
            rw        <= RW_IDLE;
            wr_data   <= '0;
            cl_wtake  <= '0;
            cl_rvalid <= '0;
            cl_rdata  <= '0;
            lat_rd    <= 1'b0;
            lat_dev   <= '0;
            lat_addr  <= '0;
            lat_len   <= '0;
            cnt       <= '0;
            rphase    <= 1'b0;
        end else begin
            cl_wtake  <= '0;
            cl_rvalid <= '0;
            done      <= '0;
            case (state)
                S_IDLE: begin
                    if (|req && bus_idle) begin
                        gnt      <= arb_gnt;
                        sel      <= win_idx;
                        busy     <= 1'b1;
                        rw       <= RW_WR;
                        lat_rd   <= req_rd[win_idx];
                        lat_dev  <= dev_a[win_idx];
                        lat_addr <= addr_a[win_idx];
                        lat_len  <= win_len;
                        cnt      <= '0;
                        rphase   <= 1'b0;
                        ptr      <= ptr_next;
                        state    <= S_WLO;
                    end
                end
                S_WLO: begin
                    if (!wr_ready) begin
                        if (rphase) begin
                            wr_data <= lat_dev | I2C_RD_BIT;
                        end else if (cnt == 7'd0) begin
                            wr_data <= lat_dev;
                        end else if (cnt == 7'd1) begin
                            wr_data <= lat_addr;
                        end else begin
                            wr_data  <= wdata_a[sel];
                            cl_wtake <= gnt;
                        end
                        if (!rphase) cnt <= cnt + 7'd1;
                        state <= S_WHI;
                    end
                end
                S_WHI: begin
                    if (wr_ready) begin
                        if (rphase) begin
                            state <= S_RARM;
                        end else if (cnt < wr_total) begin
                            state <= S_WLO;
                        end else begin
                            cnt   <= '0;
                            rw    <= RW_IDLE;
                            state <= (lat_rd && lat_len != 7'd0) ? S_RIDLE : S_FIN;
                        end
                    end
                end
                S_RIDLE: begin
                    if (bus_idle) begin
                        rw     <= RW_RD;
                        rphase <= 1'b1;
                        state  <= S_WLO;
                    end
                end
                S_RARM: begin
                    if (!wr_ready) state <= S_RLO;
                end
                S_RLO: begin
                    if (!rd_ready) begin
                        // Dropping rw before the last byte completes makes the master NACK it.
                        if (cnt == lat_len - 7'd1) rw <= RW_IDLE;
                        state <= S_RHI;
                    end
                end
                S_RHI: begin
                    if (rd_ready) begin
                        cl_rdata  <= rd_in;
                        cl_rvalid <= gnt;
                        cnt       <= cnt + 7'd1;
                        state     <= (cnt + 7'd1 < lat_len) ? S_RLO : S_FIN;
                    end
                end
                S_FIN: begin
                    rw <= RW_IDLE;
                    if (bus_idle) begin
                        done  <= gnt;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xact_sched.sv
// tb/tb_i2c_xact_sched.sv - directed self-checking bench for i2c_xact_sched
module tb_i2c_xact_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0, req_rd = '0;
    logic [15:0] req_dev = '0, req_addr = '0, cl_wdata = '0;
    logic [13:0] req_len = '0;
    logic [1:0]  cl_wtake, cl_rvalid, gnt, done, rw;
    logic [7:0]  cl_rdata, wr_data;
    logic        busy;
    logic        sclk = 1'b1, sda = 1'b1, wr_ready = 1'b1, rd_ready = 1'b1;
    logic [7:0]  rd_in = '0;

    int          vectors = 0;
    int          errors  = 0;
    int          n, takes;
    logic [7:0]  b, last;
    logic [1:0]  tk;
    logic [7:0]  wexp [5] = '{8'hd0, 8'h08, 8'h01, 8'h02, 8'h03};
    logic [7:0]  rdv  [3] = '{8'haa, 8'hbb, 8'hcc};

    always #5 clk = ~clk;

    i2c_xact_sched #(.NREQ(2), .MAXLEN(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rd(req_rd), .req_dev(req_dev),
        .req_addr(req_addr), .req_len(req_len), .cl_wdata(cl_wdata),
        .cl_wtake(cl_wtake), .cl_rdata(cl_rdata), .cl_rvalid(cl_rvalid),
        .gnt(gnt), .done(done), .busy(busy), .sclk(sclk), .sda(sda), .rw(rw),
        .wr_data(wr_data), .wr_ready(wr_ready), .rd_ready(rd_ready), .rd_in(rd_in)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_client(input int c, input logic rd, input logic [7:0] dev,
                              input logic [7:0] addr, input logic [6:0] len, input logic [7:0] wd);
        req_rd[c]            = rd;
        req_dev[c*8 +: 8]    = dev;
        req_addr[c*8 +: 8]   = addr;
        req_len[c*7 +: 7]    = len;
        cl_wdata[c*8 +: 8]   = wd;
    endtask

    // Master write handshake: one edge with wr_ready low (byte loads), one edge high.
    task automatic wr_byte(output logic [7:0] bo, output logic [1:0] tko);
        wr_ready = 1'b0;
        step();
        bo  = wr_data;
        tko = cl_wtake;
        if (cl_wtake[0]) cl_wdata[7:0]  = cl_wdata[7:0] + 8'd1;
        if (cl_wtake[1]) cl_wdata[15:8] = cl_wdata[15:8] + 8'd1;
        wr_ready = 1'b1;
        step();
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rw", rw, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_pulses", {cl_wtake, cl_rvalid, cl_rdata}, 0);

        // Write: client0 d0/08 len 3, data 01 02 03
        set_client(0, 1'b0, 8'hd0, 8'h08, 7'd3, 8'h01);
        req = 2'b01;
        step();
        chk("wr_gnt", gnt, 2'b01);
        chk("wr_busy", busy, 1);
        chk("wr_rw", rw, 2'b10);
        takes = 0;
        for (int i = 0; i < 5; i++) begin
            wr_byte(b, tk);
            chk("wr_byte", b, wexp[i]);
            chk("wr_take", tk, (i >= 2) ? 2'b01 : 2'b00);
        end
        chk("wr_rw_stop", rw, 2'b00);
        sda = 1'b0;
        step();
        chk("wr_fin_wait_done", done, 0);
        chk("wr_fin_wait_gnt", gnt, 2'b01);
        sda = 1'b1;
        step();
        chk("wr_done", done, 2'b01);
        chk("wr_done_gnt", gnt, 0);
        chk("wr_done_busy", busy, 0);
        req = 2'b00;
        step();
        chk("wr_done_width", done, 0);

        // Read: client1 d0/08 len 3, master returns aa bb cc
        set_client(1, 1'b1, 8'hd0, 8'h08, 7'd3, 8'h00);
        req = 2'b10;
        step();
        chk("rd_gnt", gnt, 2'b10);
        wr_byte(b, tk); chk("rd_dev", b, 8'hd0);
        wr_byte(b, tk); chk("rd_addr", b, 8'h08);
        chk("rd_no_take", tk, 0);
        chk("rd_rw_stop", rw, 2'b00);
        step();
        chk("rd_rw_read", rw, 2'b01);
        wr_byte(b, tk); chk("rd_devrd", b, 8'hd1);
        wr_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            rd_ready = 1'b0;
            step();
            chk("rd_rw_nack", rw, (i == 2) ? 2'b00 : 2'b01);
            chk("rd_rvalid_gap", cl_rvalid, 0);
            rd_in    = rdv[i];
            rd_ready = 1'b1;
            step();
            chk("rd_rvalid", cl_rvalid, 2'b10);
            chk("rd_rdata", cl_rdata, rdv[i]);
        end
        step();
        chk("rd_done", done, 2'b10);
        chk("rd_rdata_hold", cl_rdata, 8'hcc);
        req = 2'b00;
        wr_ready = 1'b1;
        step();

        // Contention from reset: 0, then 1, then 0 again
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_client(0, 1'b0, 8'hd0, 8'h10, 7'd0, 8'h00);
        set_client(1, 1'b0, 8'ha0, 8'h20, 7'd0, 8'h00);
        req = 2'b11;
        step();
        chk("rr_first", gnt, 2'b01);
        wr_byte(b, tk); chk("rr_first_dev", b, 8'hd0);
        wr_byte(b, tk);
        step();
        chk("rr_first_done", done, 2'b01);
        chk("rr_no_gnt_in_done", gnt, 0);
        step();
        chk("rr_second", gnt, 2'b10);
        wr_byte(b, tk); chk("rr_second_dev", b, 8'ha0);
        wr_byte(b, tk); chk("rr_second_addr", b, 8'h20);
        step();
        chk("rr_second_done", done, 2'b10);
        step();
        chk("rr_third", gnt, 2'b01);
        wr_byte(b, tk);
        wr_byte(b, tk);
        step();
        chk("rr_third_done", done, 2'b01);
        req = 2'b00;
        step();

        // Read with len 0: header only, no repeated start
        set_client(0, 1'b1, 8'hd0, 8'h08, 7'd0, 8'h00);
        req = 2'b01;
        step();
        chk("rd0_gnt", gnt, 2'b01);
        wr_byte(b, tk); chk("rd0_dev", b, 8'hd0);
        wr_byte(b, tk); chk("rd0_addr", b, 8'h08);
        chk("rd0_rw", rw, 2'b00);
        step();
        chk("rd0_done", done, 2'b01);
        chk("rd0_rw_after", rw, 2'b00);
        req = 2'b00;
        step();

        // len 100 saturates to 64 payload bytes
        set_client(1, 1'b0, 8'ha0, 8'h00, 7'd100, 8'h00);
        req = 2'b10;
        step();
        chk("sat_gnt", gnt, 2'b10);
        wr_byte(b, tk);
        wr_byte(b, tk);
        n = 0;
        takes = 0;
        last = '0;
        for (int i = 0; i < 80 && rw != 2'b00; i++) begin
            wr_byte(b, tk);
            n++;
            last = b;
            if (tk[1]) takes++;
        end
        chk("sat_bytes", n, 64);
        chk("sat_takes", takes, 64);
        chk("sat_last", last, 8'h3f);
        step();
        chk("sat_done", done, 2'b10);
        req = 2'b00;
        step();

        // Bus busy holds off the grant
        set_client(0, 1'b0, 8'hd0, 8'h08, 7'd0, 8'h00);
        sda = 1'b0;
        req = 2'b01;
        step(); step(); step();
        chk("busy_bus_gnt", gnt, 0);
        chk("busy_bus_busy", busy, 0);
        sda = 1'b1;
        step();
        chk("busy_bus_gnt_late", gnt, 2'b01);
        wr_byte(b, tk);
        wr_byte(b, tk);
        step();
        chk("busy_bus_done", done, 2'b01);
        req = 2'b00;
        step();

        // Reset while waiting in RHI after byte 1 of 3
        set_client(0, 1'b1, 8'hd0, 8'h08, 7'd3, 8'h00);
        req = 2'b01;
        step();
        wr_byte(b, tk);
        wr_byte(b, tk);
        step();
        wr_byte(b, tk);
        wr_ready = 1'b0;
        step();
        rd_ready = 1'b0;
        step();
        rd_in    = 8'h55;
        rd_ready = 1'b1;
        step();
        chk("mid_rvalid", cl_rvalid, 2'b01);
        chk("mid_rdata", cl_rdata, 8'h55);
        rd_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rw", rw, 0);
        chk("mid_rst_rdata", cl_rdata, 0);
        chk("mid_rst_done", done, 0);
        wr_ready = 1'b1;
        rd_ready = 1'b1;
        set_client(0, 1'b0, 8'hd0, 8'h08, 7'd1, 8'h5a);
        step();
        chk("post_rst_done", done, 0);
        chk("post_rst_gnt", gnt, 2'b01);
        wr_byte(b, tk); chk("post_rst_dev", b, 8'hd0);
        wr_byte(b, tk); chk("post_rst_addr", b, 8'h08);
        wr_byte(b, tk); chk("post_rst_data", b, 8'h5a);
        chk("post_rst_take", tk, 2'b01);
        step();
        chk("post_rst_xact_done", done, 2'b01);
        req = 2'b00;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/i2c_xact_sched.md
# i2c_xact_sched

Transaction scheduler that shares the single I2C byte master between `NREQ` client blocks (RTC poller, RAM test, config loader). It takes whole register-level transactions (device, register address, length, direction) and arbitrates between them round-robin. It sequences the master's `rw`/`wr_ready`/`rd_ready` byte handshake, including the address-write plus repeated-address read sequence. Clients only stream payload bytes.

## Interface
- `NREQ`, 2: number of clients, 2..4.
- `MAXLEN`, 64: maximum payload bytes per transaction.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: client `i` requests a transaction; held until its `done` pulse.
- `req_rd` in NREQ: 1 = read, 0 = write.
- `req_dev` in NREQ*8: device address byte with R/W bit 0 (e.g. 8'hd0).
- `req_addr` in NREQ*8: register/RAM start address.
- `req_len` in NREQ*7: payload byte count, 0..MAXLEN.
- `cl_wdata` in NREQ*8: next write byte from each client.
- `cl_wtake` out NREQ: one-cycle pulse; the granted client's current byte was consumed and it must present the next byte.
- `cl_rdata` out 8: read byte.
- `cl_rvalid` out NREQ: one-cycle pulse; `cl_rdata` is valid for that client.
- `gnt` out NREQ: one-hot grant, held for the whole transaction.
- `done` out NREQ: one-cycle pulse at the end of the transaction.
- `busy` out 1: a transaction is in progress.
- `sclk`, `sda` in 1: bus lines, sampled. Bus idle = `sclk && sda`.
- `rw` out 2: master command. 2'b10 write, 2'b01 read, 2'b00 stop/idle.
- `wr_data` out 8: byte to master.
- `wr_ready` in 1: master byte-write handshake.
- `rd_ready` in 1: master byte-read handshake.
- `rd_in` in 8: byte from master.

## Operation
- Reset: all outputs 0, state IDLE, round-robin pointer 0 (client 0 has highest priority first).
- IDLE: if any `req` and bus idle, the rr_arbiter picks the first requester at or after the pointer.
  - Latch its fields. `req_len` above MAXLEN saturates to MAXLEN.
  - Set `gnt`, `busy`, and `rw`=10. Go to WLO.
  - The pointer advances to winner+1 mod NREQ.
- Write byte sequence: dev, addr, then `len` payload bytes for a write. A read uses dev, addr only.
  - WLO: wait `!wr_ready`; drive `wr_data` with the next byte; go to WHI.
  - For payload bytes, `cl_wtake` pulses for the granted client in the same cycle `wr_data` loads.
  - WHI: wait `wr_ready`. If bytes remain, go to WLO. Otherwise reset the byte counter and set `rw`=00.
  - Write transaction: go to FIN.
  - Read transaction with len=0: go to FIN.
  - Read transaction with len>0: go to RIDLE.
- RIDLE: wait bus idle; set `rw`=01; single byte `req_dev|8'h01` through WLO/WHI; then go to RARM.
- RARM: wait `!wr_ready`; go to RLO.
- RLO: wait `!rd_ready`. If this is the last byte (count==len-1), set `rw`=00 here, before the last byte completes, so the master NACKs and stops. Go to RHI.
- RHI: wait `rd_ready`; `cl_rdata`←`rd_in`; pulse `cl_rvalid`; count+1. If count<len go to RLO, else go to FIN.
- FIN: `rw`=00; wait bus idle. Then pulse `done`, clear `gnt` and `busy`, and return to IDLE. No grant is given in the `done` cycle.
- Simultaneous requests: rr order decides. A `req` deasserted mid-transaction is ignored; the transaction always completes.
- `rst` mid-transaction: next edge forces reset values. `rw`=00 releases the master. No `done` pulse.

## Timing
- Grant latency: `gnt` rises 1 cycle after the `req` and bus-idle edge.
- Every master handshake wait is level-sensitive with unbounded length. Each state transition costs 1 clk.
- `cl_wtake`/`cl_rvalid`/`done` are exactly 1 cycle wide. `cl_rdata` holds until the next `cl_rvalid`.
- Byte counter is 7 bits and compared against the latched len; it never wraps because len ≤ MAXLEN ≤ 64.

## Structure
- Package `i2c_pkg`:
  - `rw` constants RW_IDLE=2'b00, RW_WR=2'b10, RW_RD=2'b01.
  - Scheduler state enum.
  - `I2C_RD_BIT`=8'h01.
- Sub-module `rr_arbiter` (NREQ, request vector, pointer → one-hot grant, combinational).
- Everything else in `i2c_xact_sched`.

## Test plan
- Write: client0 sends dev=d0, addr=08, len=3, data 01,02,03 → master BFM sees rw=10 bytes d0,08,01,02,03. `cl_wtake[0]` pulses 3 times. Then rw=00, `done[0]` after bus idle.
- Read: client1 sends d0, 08, len=3; BFM returns AA,BB,CC → bytes d0,08 (rw=10), then rw=01 byte d1. `cl_rvalid[1]` ×3 with AA,BB,CC. rw=00 asserted at the third `!rd_ready`.
- Contention: `req`=2'b11 in the same cycle from reset → client0 served first, then client1. Both again → client1 first next round.
- Boundaries:
  - Read len=0 → only d0,08 written, no rw=01, `done` pulses.
  - len=100 → exactly 64 payload bytes.
- Bus busy: hold sda=0 with a request pending → no `gnt` until `sclk&&sda`. Then `gnt` arrives 1 cycle later.
- Reset in RHI after byte 1 of 3 → next cycle all outputs 0, no `done`. A new request is then served normally.
